fc_psum_accum: RTL and testbench

- Sits directly downstream of the bottom PE of each fully-connected systolic column; consumes the column's psum_out stream, one partial sum per output neuron per input tile.
- Accumulates partial sums across NUM_TILE input-feature tiles in a local accumulator bank.
- On the last tile, saturates and emits each finished neuron value over a valid/ready interface to the output writer.

---
 rtl/fc_psum_accum.sv | 188 ++++++++++++++++++
 tb/tb_fc_psum_accum.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_psum_accum.sv
// fc_psum_accum: partial-sum accumulator placed below a fully-connected
// systolic column. Accumulates one psum per neuron per input tile, then
// saturates each finished neuron and streams it out on a valid/ready port.
// Optional build macro: FC_RELU_EN (fuses a ReLU clamp after saturation).
module fc_psum_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int DEPTH      = 64,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_num_neuron,
  input  logic [CNT_WIDTH-1:0]  cfg_num_tile,
  input  logic [DATA_WIDTH-1:0] psum_in,
  input  logic                  psum_valid,
  output logic                  psum_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   neuron_cnt_q, neuron_cnt_d;
  logic [CNT_WIDTH-1:0]   tile_cnt_q, tile_cnt_d;
  logic [CNT_WIDTH-1:0]   cfg_neuron_q, cfg_neuron_d;
  logic [CNT_WIDTH-1:0]   cfg_tile_q, cfg_tile_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  // Accumulator bank; contents are don't-care until tile 0 overwrites them.
  logic [ACC_WIDTH-1:0]   acc_mem [DEPTH];

  logic                   last_tile;
  logic                   last_neuron;
  logic                   ready_int;
  logic                   accept;
  logic [ACC_WIDTH-1:0]   psum_ext;
  logic [ACC_WIDTH-1:0]   sum;
  logic                   sat_hi;
  logic                   sat_lo;
  logic [OUT_WIDTH-1:0]   sat_val;
  logic [OUT_WIDTH-1:0]   result;
  logic                   acc_we;

  // Handshake qualification, accumulate datapath, saturation and ReLU.
  always_comb begin
    last_tile   = (tile_cnt_q == cfg_tile_q);
    last_neuron = (neuron_cnt_q == cfg_neuron_q);
    // Stall only on the last tile, where an accept would overwrite a result
    // still waiting for the downstream writer.
    ready_int   = (state_q == S_ACCUM) && !(last_tile && out_valid_q && !out_ready);
    accept      = psum_valid && ready_int;
    psum_ext    = ACC_WIDTH'(signed'(psum_in));
    sum         = (tile_cnt_q == '0) ? psum_ext : (acc_mem[neuron_cnt_q] + psum_ext);
    sat_hi      = !sum[ACC_WIDTH-1] && (|sum[ACC_WIDTH-2:OUT_WIDTH-1]);
    sat_lo      =  sum[ACC_WIDTH-1] && !(&sum[ACC_WIDTH-2:OUT_WIDTH-1]);
    if (sat_hi) begin
      sat_val = OUT_MAX;
    end else if (sat_lo) begin
      sat_val = OUT_MIN;
    end else begin
      sat_val = sum[OUT_WIDTH-1:0];
    end
`ifdef FC_RELU_EN
    result = sat_val[OUT_WIDTH-1] ? '0 : sat_val;
`else
    result = sat_val;
`endif
    acc_we = accept && !last_tile;
  end

  // Next-state logic for the pass FSM, counters, config and output register.
  always_comb begin
    state_d      = state_q;
    neuron_cnt_d = neuron_cnt_q;
    tile_cnt_d   = tile_cnt_q;
    cfg_neuron_d = cfg_neuron_q;
    cfg_tile_d   = cfg_tile_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    done_d       = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_ACCUM;
          cfg_neuron_d = cfg_num_neuron;
          cfg_tile_d   = cfg_num_tile;
          neuron_cnt_d = '0;
          tile_cnt_d   = '0;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          // A new result may load in the same cycle the old one drains.
          if (last_tile) begin
            out_valid_d = 1'b1;
            out_data_d  = result;
          end
          if (last_neuron) begin
            neuron_cnt_d = '0;
            if (last_tile) begin
              state_d = S_FLUSH;
            end else begin
              tile_cnt_d = tile_cnt_q + CNT_WIDTH'(1);
            end
          end else begin
            neuron_cnt_d = neuron_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      S_FLUSH: begin
        if (!out_valid_q || out_ready) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers with asynchronous abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      neuron_cnt_q <= '0;
      tile_cnt_q   <= '0;
      cfg_neuron_q <= '0;
      cfg_tile_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      neuron_cnt_q <= neuron_cnt_d;
      tile_cnt_q   <= tile_cnt_d;
      cfg_neuron_q <= cfg_neuron_d;
      cfg_tile_q   <= cfg_tile_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  // Accumulator bank write; the last tile streams out instead of writing back.
  always_ff @(posedge clk) begin
    if (acc_we) begin
      acc_mem[neuron_cnt_q] <= sum;
    end
  end

  assign psum_ready = ready_int;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fc_psum_accum.sv
// Self-checking bench for fc_psum_accum: directed scenarios plus randomized
// passes compared against a sum-over-tiles reference model.
module tb_fc_psum_accum;

  localparam int DW    = 16;
  localparam int AW    = 24;
  localparam int OW    = 16;
  localparam int DEPTH = 64;
  localparam int CW    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] cfg_num_neuron;
  logic [CW-1:0] cfg_num_tile;
  logic [DW-1:0] psum_in;
  logic          psum_valid;
  logic          psum_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int            vectors = 0;
  int            errs    = 0;
  logic [DW-1:0] ps_q[$];
  int            exp_q[$];
  int            got_q[$];
  int            done_cnt = 0;
  bit            pass_end;

  fc_psum_accum #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .OUT_WIDTH (OW),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CW)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_num_neuron(cfg_num_neuron),
    .cfg_num_tile  (cfg_num_tile),
    .psum_in       (psum_in),
    .psum_valid    (psum_valid),
    .psum_ready    (psum_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Output and done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) got_q.push_back(int'($signed(out_data)));
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: wrap to the accumulator width, saturate, optional ReLU.
  function automatic int post(input longint s);
    logic [AW-1:0] w;
    longint        v;
    w = s[AW-1:0];
    v = longint'($signed(w));
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`ifdef FC_RELU_EN
    if (v < 0) v = 0;
`endif
    return int'(v);
  endfunction

  // ps_q is tile-major: index = tile*(nn+1) + neuron.
  task automatic build_exp(input int nn, input int nt);
    exp_q.delete();
    for (int n = 0; n <= nn; n++) begin
      longint s = 0;
      for (int t = 0; t <= nt; t++) begin
        int p;
        p = int'($signed(ps_q[t*(nn+1)+n]));
        s += longint'(p);
      end
      exp_q.push_back(post(s));
    end
  endtask

  task automatic start_pass(input int nn, input int nt);
    cfg_num_neuron = CW'(nn);
    cfg_num_tile   = CW'(nt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_psum(input logic [DW-1:0] v, output int waits);
    psum_valid = 1'b1;
    psum_in    = v;
    waits      = 0;
    @(negedge clk);
    while (!psum_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!psum_ready) check("psum_accept_timeout", 32'(psum_ready), 1);
    @(posedge clk); #1;
    psum_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("done_seen", 32'(done), 1);
    @(posedge clk); #1;
  endtask

  task automatic compare_out(input string tag);
    int n;
    check({tag, "_beats"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_data"}, got_q[i], exp_q[i]);
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  task automatic feed_all(input bit rnd);
    int w;
    foreach (ps_q[i]) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      drive_psum(ps_q[i], w);
    end
  endtask

  task automatic run_pass(input string tag, input int nn, input int nt, input bit rnd);
    got_q.delete();
    done_cnt = 0;
    build_exp(nn, nt);
    start_pass(nn, nt);
    if (rnd) begin
      pass_end = 1'b0;
      fork
        begin
          feed_all(1'b1);
          wait_done();
          pass_end = 1'b1;
        end
        begin
          while (!pass_end) begin
            @(posedge clk); #1;
            if (!pass_end) out_ready = 1'($urandom_range(0, 1));
          end
        end
      join
      out_ready = 1'b1;
    end else begin
      feed_all(1'b0);
      wait_done();
    end
    compare_out(tag);
  endtask

  initial begin
    int w;
    int nn;
    int nt;

    rst_n = 1'b0; start = 1'b0; cfg_num_neuron = '0; cfg_num_tile = '0;
    psum_in = '0; psum_valid = 1'b0; out_ready = 1'b1;

    // Reset state.
    #12;
    check("rst_out_data",   $signed(out_data), 0);
    check("rst_out_valid",  32'(out_valid), 0);
    check("rst_psum_ready", 32'(psum_ready), 0);
    check("rst_busy",       32'(busy), 0);
    check("rst_done",       32'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single tile: one-cycle latency per result.
    ps_q = '{16'd5, 16'hFFF9, 16'd100, 16'd0};
    build_exp(3, 0);
    got_q.delete(); done_cnt = 0;
    start_pass(3, 0);
    check("st_busy", 32'(busy), 1);
    foreach (ps_q[i]) begin
      drive_psum(ps_q[i], w);
      check("st_valid", 32'(out_valid), 1);
      check("st_data",  $signed(out_data), exp_q[i]);
    end
    wait_done();
    check("st_busy_after", 32'(busy), 0);
    compare_out("single");

    // Multi-tile.
    ps_q = '{16'd10, 16'hFFFF, 16'd20, 16'hFFFE, 16'd30, 16'hFFFD};
    run_pass("multi", 1, 2, 1'b0);

    // Saturation both directions.
    ps_q = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    run_pass("sat_pos", 0, 3, 1'b0);
    ps_q = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    run_pass("sat_neg", 0, 3, 1'b0);

    // Backpressure on the last tile.
    ps_q.delete();
    for (int i = 0; i < 8; i++) ps_q.push_back(16'($urandom_range(0, 16'hFFFF)));
    build_exp(3, 1);
    got_q.delete(); done_cnt = 0;
    start_pass(3, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_psum(ps_q[i], w);
    psum_valid = 1'b1;
    psum_in    = ps_q[5];
    repeat (5) begin
      @(negedge clk);
      check("bp_psum_ready", 32'(psum_ready), 0);
      check("bp_out_valid",  32'(out_valid), 1);
      check("bp_out_data",   $signed(out_data), exp_q[0]);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 5; i < 8; i++) begin
      drive_psum(ps_q[i], w);
      check("bp_no_wait",  w, 0);
      check("bp_valid",    32'(out_valid), 1);
      check("bp_data",     $signed(out_data), exp_q[i-4]);
    end
    wait_done();
    compare_out("backpressure");

    // Mid-pass reset with a result pending.
    start_pass(1, 1);
    out_ready = 1'b0;
    drive_psum(16'd3, w);
    drive_psum(16'd4, w);
    drive_psum(16'd5, w);
    check("mr_pending_valid", 32'(out_valid), 1);
    check("mr_pending_data",  $signed(out_data), post(8));
    #3 rst_n = 1'b0;
    #1;
    check("mr_out_valid",  32'(out_valid), 0);
    check("mr_out_data",   $signed(out_data), 0);
    check("mr_psum_ready", 32'(psum_ready), 0);
    check("mr_busy",       32'(busy), 0);
    check("mr_done",       32'(done), 0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    ps_q = '{16'd9};
    run_pass("after_reset", 0, 0, 1'b0);

    // Start while busy is ignored.
    ps_q.delete();
    for (int i = 0; i < 4; i++) ps_q.push_back(16'($urandom_range(0, 16'hFFFF)));
    build_exp(1, 1);
    got_q.delete(); done_cnt = 0;
    start_pass(1, 1);
    drive_psum(ps_q[0], w);
    cfg_num_neuron = CW'(5);
    cfg_num_tile   = CW'(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 4; i++) drive_psum(ps_q[i], w);
    wait_done();
    compare_out("start_busy");

    // Randomized passes with random bubbles and output stalls.
    repeat (6) begin
      nn = int'($urandom_range(0, 7));
      nt = int'($urandom_range(0, 3));
      ps_q.delete();
      for (int i = 0; i < (nn+1)*(nt+1); i++) ps_q.push_back(16'($urandom_range(0, 16'hFFFF)));
      run_pass("random", nn, nt, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
